// File: rtl/axis_ad5791.sv
// Parallel SPI driver for four AD5791 DACs (X/Y/Z/U) sharing SCLK and SYNC_n.
// Define AXIS_AD5791_LDAC_EN to pulse LDAC_n after each frame; otherwise LDAC_n is tied low.
module axis_ad5791 #(
    parameter int SCLK_DIV = 2,
    parameter int SYNC_GAP = 4
) (
    input  logic        a_clk,
    input  logic        a_resetn,
    input  logic [31:0] S_AXIS1_tdata,
    input  logic        S_AXIS1_tvalid,
    input  logic [31:0] S_AXIS2_tdata,
    input  logic        S_AXIS2_tvalid,
    input  logic [31:0] S_AXIS3_tdata,
    input  logic        S_AXIS3_tvalid,
    input  logic [31:0] S_AXIS4_tdata,
    input  logic        S_AXIS4_tvalid,
    input  logic [31:0] S_AXISCFG_tdata,
    input  logic        S_AXISCFG_tvalid,
    input  logic        configuration_mode,
    input  logic [2:0]  configuration_axis,
    input  logic        configuration_send,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic [3:0]  dac_sdin,
    output logic        dac_ldac_n,
    output logic        ready
);
    localparam int PH_W  = $clog2(2 * SCLK_DIV);
    localparam int GAP_W = $clog2(SYNC_GAP);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

    state_t            state_q, state_d;
    logic [3:0][23:0]  cfg_q, cfg_d;
    logic [3:0][19:0]  hold_q, hold_d;
    logic [3:0][23:0]  shift_q, shift_d;
    logic              pend_q, pend_d;
    logic              send_prev_q, send_prev_d;
    logic              src_cfg_q, src_cfg_d;
    logic [4:0]        bit_q, bit_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              sclk_q, sclk_d;
    logic              sync_n_q, sync_n_d;
    logic [3:0]        sdin_q, sdin_d;
    logic              ready_q, ready_d;
    logic              frame_done;

    logic [3:0][31:0]  tdata_in;
    logic [3:0]        tvalid_in;
    logic              unused_bits;

    assign tdata_in  = {S_AXIS4_tdata, S_AXIS3_tdata, S_AXIS2_tdata, S_AXIS1_tdata};
    assign tvalid_in = {S_AXIS4_tvalid, S_AXIS3_tvalid, S_AXIS2_tvalid, S_AXIS1_tvalid};
    assign unused_bits = ^{S_AXISCFG_tdata[31:24], S_AXIS1_tdata[11:0], S_AXIS2_tdata[11:0],
                           S_AXIS3_tdata[11:0], S_AXIS4_tdata[11:0]};
    assign frame_done = (state_q == ST_SHIFT) && (ph_q == PH_LAST) && (bit_q == 5'd23);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        send_prev_d = configuration_send;
        src_cfg_d   = src_cfg_q;
        bit_d       = bit_q;
        ph_d        = ph_q;
        gap_d       = gap_q;
        sclk_d      = sclk_q;
        sync_n_d    = sync_n_q;
        sdin_d      = sdin_q;

        if (S_AXISCFG_tvalid && !configuration_axis[2])
            cfg_d[configuration_axis[1:0]] = S_AXISCFG_tdata[23:0];
        for (int unsigned i = 0; i < 4; i++)
            if (tvalid_in[i]) hold_d[i] = tdata_in[i][31:12];

        // The stream snapshot is taken in LOAD, so only samples arriving after it stay pending
        if (state_q == ST_LOAD && !src_cfg_q) pend_d = |tvalid_in;
        else                                  pend_d = pend_q | (|tvalid_in);

        case (state_q)
            ST_IDLE: begin
                if (configuration_mode && configuration_send && !send_prev_q) begin
                    state_d   = ST_LOAD;
                    src_cfg_d = 1'b1;
                end else if (!configuration_mode && pend_q) begin
                    state_d   = ST_LOAD;
                    src_cfg_d = 1'b0;
                end
            end
            ST_LOAD: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    shift_d[i] = src_cfg_q ? cfg_q[i] : {4'b0001, hold_q[i]};
                    sdin_d[i]  = shift_d[i][23];
                end
                sync_n_d = 1'b0;
                ph_d     = '0;
                bit_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_RISE) sclk_d = 1'b1;
                if (ph_q == PH_LAST) begin
                    sclk_d = 1'b0;
                    ph_d   = '0;
                    if (bit_q == 5'd23) begin
                        sync_n_d = 1'b1;
                        sdin_d   = '0;
                        gap_d    = '0;
                        state_d  = ST_GAP;
                    end else begin
                        bit_d = bit_q + 5'd1;
                        for (int unsigned i = 0; i < 4; i++) begin
                            shift_d[i] = {shift_q[i][22:0], 1'b0};
                            sdin_d[i]  = shift_q[i][22];
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE) && (configuration_mode || !pend_d);
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            hold_q      <= '0;
            shift_q     <= '0;
            pend_q      <= 1'b0;
            send_prev_q <= 1'b0;
            src_cfg_q   <= 1'b0;
            bit_q       <= '0;
            ph_q        <= '0;
            gap_q       <= '0;
            sclk_q      <= 1'b0;
            sync_n_q    <= 1'b1;
            sdin_q      <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            send_prev_q <= send_prev_d;
            src_cfg_q   <= src_cfg_d;
            bit_q       <= bit_d;
            ph_q        <= ph_d;
            gap_q       <= gap_d;
            sclk_q      <= sclk_d;
            sync_n_q    <= sync_n_d;
            sdin_q      <= sdin_d;
            ready_q     <= ready_d;
        end
    end

`ifdef AXIS_AD5791_LDAC_EN
    logic            ldac_n_q, ldac_n_d;
    logic [PH_W-1:0] ldac_cnt_q, ldac_cnt_d;

    // Runs independently of the FSM so a short SYNC_GAP cannot truncate the pulse
    always_comb begin
        ldac_n_d   = ldac_n_q;
        ldac_cnt_d = ldac_cnt_q;
        if (frame_done) begin
            ldac_n_d   = 1'b0;
            ldac_cnt_d = '0;
        end else if (!ldac_n_q) begin
            ldac_cnt_d = ldac_cnt_q + 1'b1;
            if (ldac_cnt_q == PH_LAST) ldac_n_d = 1'b1;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            ldac_n_q   <= 1'b1;
            ldac_cnt_q <= '0;
        end else begin
            ldac_n_q   <= ldac_n_d;
            ldac_cnt_q <= ldac_cnt_d;
        end
    end

    assign dac_ldac_n = ldac_n_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign dac_ldac_n = 1'b0;
`endif

    assign dac_sclk   = sclk_q;
    assign dac_sync_n = sync_n_q;
    assign dac_sdin   = sdin_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_axis_ad5791.sv
// Self-checking bench for axis_ad5791: frames are reassembled from the serial pins
// and compared against word values derived from the cfg/sample model kept here.
module tb_axis_ad5791;
    localparam int DIV = 2;
    localparam int GAP = 4;

    logic        a_clk = 1'b0;
    logic        a_resetn = 1'b0;
    logic [31:0] s1_tdata = '0, s2_tdata = '0, s3_tdata = '0, s4_tdata = '0;
    logic        s1_tvalid = 1'b0, s2_tvalid = 1'b0, s3_tvalid = 1'b0, s4_tvalid = 1'b0;
    logic [31:0] cfg_tdata = '0;
    logic        cfg_tvalid = 1'b0;
    logic        configuration_mode = 1'b0;
    logic [2:0]  configuration_axis = '0;
    logic        configuration_send = 1'b0;
    logic        dac_sclk, dac_sync_n, dac_ldac_n, ready;
    logic [3:0]  dac_sdin;

    axis_ad5791 #(.SCLK_DIV(DIV), .SYNC_GAP(GAP)) dut (
        .a_clk(a_clk), .a_resetn(a_resetn),
        .S_AXIS1_tdata(s1_tdata), .S_AXIS1_tvalid(s1_tvalid),
        .S_AXIS2_tdata(s2_tdata), .S_AXIS2_tvalid(s2_tvalid),
        .S_AXIS3_tdata(s3_tdata), .S_AXIS3_tvalid(s3_tvalid),
        .S_AXIS4_tdata(s4_tdata), .S_AXIS4_tvalid(s4_tvalid),
        .S_AXISCFG_tdata(cfg_tdata), .S_AXISCFG_tvalid(cfg_tvalid),
        .configuration_mode(configuration_mode), .configuration_axis(configuration_axis),
        .configuration_send(configuration_send),
        .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n), .dac_sdin(dac_sdin),
        .dac_ldac_n(dac_ldac_n), .ready(ready)
    );

    always #5 a_clk = ~a_clk;

    typedef struct {
        int unsigned      nbits;
        logic [3:0][23:0] w;
    } frame_t;

    frame_t           frames[$];
    int unsigned      sclk_rises = 0;
    int unsigned      nbits = 0;
    logic [3:0][23:0] cap = '0;
    logic             sync_prev = 1'b1, sclk_prev = 1'b0;
    int unsigned      ldac_run = 0;
    int unsigned      ldac_runs[$];
    int unsigned      ldac_bad = 0;

    int               checks = 0, errors = 0;
    logic [23:0]      cfg_m[4];
    logic [31:0]      hold_m[4];
    int unsigned      full_frames = 0;

    // Pin-level monitor: data is taken on SCLK rising (mid-bit), frames close on SYNC_n rising
    always @(negedge a_clk) begin
        frame_t f;
        if (sync_prev && !dac_sync_n) begin
            nbits = 0;
            cap = '0;
        end
        if (!sclk_prev && dac_sclk) begin
            sclk_rises++;
            if (!dac_sync_n) begin
                for (int l = 0; l < 4; l++) cap[l] = {cap[l][22:0], dac_sdin[l]};
                nbits++;
            end
        end
        if (!sync_prev && dac_sync_n) begin
            f.nbits = nbits;
            f.w = cap;
            frames.push_back(f);
        end
        if (dac_ldac_n === 1'b0) ldac_run++;
        else if (ldac_run != 0) begin
            ldac_runs.push_back(ldac_run);
            ldac_run = 0;
        end
        if (dac_ldac_n !== 1'b0) ldac_bad++;
        sync_prev = dac_sync_n;
        sclk_prev = dac_sclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge a_clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int unsigned axis, input logic [31:0] data);
        configuration_axis = 3'(axis);
        cfg_tdata = data;
        cfg_tvalid = 1'b1;
        cycles(1);
        cfg_tvalid = 1'b0;
        if (axis < 4) cfg_m[axis] = data[23:0];
    endtask

    task automatic pulse_send();
        configuration_send = 1'b1;
        cycles(1);
        configuration_send = 1'b0;
    endtask

    task automatic drive_samples(input logic [3:0] vm, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [31:0] u);
        s1_tdata = x; s2_tdata = y; s3_tdata = z; s4_tdata = u;
        {s4_tvalid, s3_tvalid, s2_tvalid, s1_tvalid} = vm;
        cycles(1);
        {s4_tvalid, s3_tvalid, s2_tvalid, s1_tvalid} = '0;
        if (vm[0]) hold_m[0] = x;
        if (vm[1]) hold_m[1] = y;
        if (vm[2]) hold_m[2] = z;
        if (vm[3]) hold_m[3] = u;
    endtask

    function automatic logic [3:0][23:0] cfg_exp();
        logic [3:0][23:0] r;
        for (int l = 0; l < 4; l++) r[l] = cfg_m[l];
        return r;
    endfunction

    // DAC-register write (address 1) carrying the top 20 bits of each held sample
    function automatic logic [3:0][23:0] stream_exp();
        logic [3:0][23:0] r;
        for (int l = 0; l < 4; l++) r[l] = 24'((32'h1 << 20) + (hold_m[l] >> 12));
        return r;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            cycles(1);
            n++;
        end
        check({tag, "_ready"}, ready, 1);
    endtask

    task automatic check_frame(input string tag, input logic [3:0][23:0] exp);
        frame_t f;
        int n = 0;
        while (frames.size() == 0 && n < 1000) begin
            cycles(1);
            n++;
        end
        check({tag, "_present"}, frames.size() > 0, 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check({tag, "_bits"}, f.nbits, 24);
            for (int l = 0; l < 4; l++) check($sformatf("%s_lane%0d", tag, l), f.w[l], exp[l]);
            full_frames++;
        end
    endtask

    initial begin
        int unsigned s0;
        int lat;
        int n;
        logic [3:0][23:0] old;

        for (int l = 0; l < 4; l++) begin
            cfg_m[l] = '0;
            hold_m[l] = '0;
        end

        // Reset values
        cycles(3);
        check("rst_sync_n", dac_sync_n, 1);
        check("rst_sclk", dac_sclk, 0);
        check("rst_sdin", dac_sdin, 0);
        check("rst_ready", ready, 1);
`ifdef AXIS_AD5791_LDAC_EN
        check("rst_ldac", dac_ldac_n, 1);
`else
        check("rst_ldac", dac_ldac_n, 0);
`endif
        a_resetn = 1'b1;
        cycles(200);
        check("idle_sclk", sclk_rises, 0);
        check("idle_frames", frames.size(), 0);
        check("idle_ready", ready, 1);

        // Config frame with the documented lane values
        configuration_mode = 1'b1;
        cycles(1);
        cfg_write(3, 128);
        cfg_write(2, 64);
        cfg_write(1, 32);
        cfg_write(0, 16);
        s0 = sclk_rises;
        pulse_send();
        lat = 1;
        if (ready) begin
            cycles(1);
            lat++;
        end
        check("cfg_ready_fall", ready, 0);
        while (ready !== 1'b1 && lat < 1000) begin
            cycles(1);
            lat++;
        end
        check("cfg_ready_rise", ready, 1);
        check("cfg_busy_len", (lat >= 48 * DIV + GAP) && (lat <= 48 * DIV + GAP + 3), 1);
        check_frame("cfg", cfg_exp());
        check("cfg_sclk_pulses", sclk_rises - s0, 24);

        // Stream frame with boundary sample values
        configuration_mode = 1'b0;
        s0 = sclk_rises;
        drive_samples(4'hF, 32'h7FFF_F000, 32'hFFFF_F000, 32'h0000_0000, 32'h8000_0000);
        check_frame("strm", stream_exp());
        wait_ready("strm");
        cycles(100);
        check("strm_one_frame", frames.size(), 0);
        check("strm_sclk_pulses", sclk_rises - s0, 24);

        // Randomized partial updates: untouched axes resend their held value
        for (int k = 0; k < 6; k++) begin
            drive_samples(4'($urandom_range(1, 15)), $urandom, $urandom, $urandom, $urandom);
            check_frame($sformatf("rnd%0d", k), stream_exp());
            wait_ready($sformatf("rnd%0d", k));
        end
        cycles(50);
        check("rnd_no_extra", frames.size(), 0);

        // Send held high for 500 cycles gives one frame
        configuration_mode = 1'b1;
        for (int unsigned a = 0; a < 4; a++) cfg_write(a, $urandom);
        configuration_send = 1'b1;
        cycles(500);
        configuration_send = 1'b0;
        check("held_one_frame", frames.size(), 1);
        check_frame("held", cfg_exp());
        cycles(50);
        check("held_no_extra", frames.size(), 0);

        // Config writes mid-frame (including an ignored axis) leave the current frame intact
        old = cfg_exp();
        pulse_send();
        n = 0;
        while (dac_sync_n !== 1'b0 && n < 100) begin
            cycles(1);
            n++;
        end
        cycles(10);
        cfg_write(2, $urandom);
        cfg_write(5, $urandom);
        cfg_write(0, $urandom);
        check_frame("midwr_old", old);
        wait_ready("midwr");
        pulse_send();
        check_frame("midwr_new", cfg_exp());
        wait_ready("midwr_new");

        // Asynchronous reset at bit 10 aborts the frame
        pulse_send();
        n = 0;
        while (nbits != 10 && n < 300) begin
            cycles(1);
            n++;
        end
        check("rst_reach_bit10", nbits, 10);
        #1 a_resetn = 1'b0;
        #1;
        check("arst_sync_n", dac_sync_n, 1);
        check("arst_sclk", dac_sclk, 0);
        check("arst_sdin", dac_sdin, 0);
        check("arst_ready", ready, 1);
        cycles(2);
        frames.delete();
        a_resetn = 1'b1;
        for (int l = 0; l < 4; l++) begin
            cfg_m[l] = '0;
            hold_m[l] = '0;
        end
        s0 = sclk_rises;
        cycles(200);
        check("arst_no_resume", frames.size(), 0);
        check("arst_no_sclk", sclk_rises - s0, 0);
        check("arst_ready_after", ready, 1);
        pulse_send();
        check_frame("post_rst_cfg", cfg_exp());
        wait_ready("post_rst");
        cycles(20);

`ifdef AXIS_AD5791_LDAC_EN
        check("ldac_pulse_count", ldac_runs.size(), full_frames);
        foreach (ldac_runs[i]) check($sformatf("ldac_len%0d", i), ldac_runs[i], 2 * DIV);
`else
        check("ldac_tied_low", ldac_bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
